// File: rtl/arbitro_balance.sv
// Shares one balance register and its add/subtract datapath between two ATM terminals, granting round-robin.
// Latency: REQ sampled in cycle N -> GNT in N+1 -> LISTO/BALANCE_STB in N+2 -> OCUPADO low in N+3.
// Backpressure: a terminal holds REQ/TIPO/MONTO until its LISTO pulse; the other requester waits in IDLE.
//
// Ports:
//   CLK, RESET (async active-low)          clock and reset
//   CARGAR_BALANCE, BALANCE_INICIAL        load the balance register (IDLE only, wins over requests)
//   REQx, TIPOx (0 dep / 1 ret), MONTOx    per-terminal request
//   GNTx, LISTOx                           grant level and one-cycle completion pulse
//   ENTREGAR_DINERO, FONDOS_INSUFICIENTES  withdrawal result, valid with LISTOx
//   BALANCE_ACTUALIZADO, BALANCE_STB       registered balance and its update strobe
//   OCUPADO                                high whenever the FSM is not IDLE
// Optional macro LIMITE_DIARIO_EN: adds a cumulative withdrawal cap (LIMITE_RETIRO) and the
// LIMITE_EXCEDIDO output; without it there is no accumulator and no cap check.
`timescale 1ns/1ps
module arbitro_balance #(
`ifdef LIMITE_DIARIO_EN
    parameter logic [63:0] LIMITE_RETIRO = 64'd500000,
`endif
    parameter int unsigned ANCHO_MONTO   = 32,
    parameter int unsigned ANCHO_BALANCE = 64
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CARGAR_BALANCE,
    input  logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL,
    input  logic                     REQ0,
    input  logic                     REQ1,
    input  logic                     TIPO0,
    input  logic                     TIPO1,
    input  logic [ANCHO_MONTO-1:0]   MONTO0,
    input  logic [ANCHO_MONTO-1:0]   MONTO1,
    output logic                     GNT0,
    output logic                     GNT1,
    output logic                     LISTO0,
    output logic                     LISTO1,
    output logic                     ENTREGAR_DINERO,
    output logic                     FONDOS_INSUFICIENTES,
`ifdef LIMITE_DIARIO_EN
    output logic                     LIMITE_EXCEDIDO,
`endif
    output logic [ANCHO_BALANCE-1:0] BALANCE_ACTUALIZADO,
    output logic                     BALANCE_STB,
    output logic                     OCUPADO
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} estado_t;

    estado_t                  estado_q, estado_d;
    logic                     ptr_q, ptr_d;       // terminal preferred on a tie
    logic                     quien_q, quien_d;   // terminal being served
    logic                     tipo_q, tipo_d;
    logic [ANCHO_MONTO-1:0]   monto_q, monto_d;
    logic [ANCHO_BALANCE-1:0] balance_q, balance_d;
    logic                     gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                     listo0_q, listo0_d, listo1_q, listo1_d;
    logic                     entregar_q, entregar_d;
    logic                     fondos_q, fondos_d;
    logic                     stb_q, stb_d;
    logic                     ocupado_q, ocupado_d;
`ifdef LIMITE_DIARIO_EN
    logic [63:0]              acc_q, acc_d;
    logic                     limite_q, limite_d;
    logic [64:0]              acc_suma;
    logic                     limite_ok;
`endif

    logic [ANCHO_BALANCE-1:0] monto_ext;
    logic [ANCHO_BALANCE:0]   suma;      // extra bit is the saturation carry
    logic                     fondos_ok;
    logic                     sel;

    assign monto_ext = ANCHO_BALANCE'(monto_q);
    assign suma      = {1'b0, balance_q} + {1'b0, monto_ext};
    assign fondos_ok = (monto_ext <= balance_q);
`ifdef LIMITE_DIARIO_EN
    assign acc_suma  = {1'b0, acc_q} + {1'b0, 64'(monto_q)};
    assign limite_ok = (acc_suma <= {1'b0, LIMITE_RETIRO});
`endif

    always_comb begin
        estado_d   = estado_q;
        ptr_d      = ptr_q;
        quien_d    = quien_q;
        tipo_d     = tipo_q;
        monto_d    = monto_q;
        balance_d  = balance_q;
        gnt0_d     = gnt0_q;
        gnt1_d     = gnt1_q;
        listo0_d   = 1'b0;
        listo1_d   = 1'b0;
        entregar_d = 1'b0;
        fondos_d   = 1'b0;
        stb_d      = 1'b0;
        sel        = 1'b0;
`ifdef LIMITE_DIARIO_EN
        acc_d      = acc_q;
        limite_d   = 1'b0;
`endif
        case (estado_q)
            IDLE: begin
                if (CARGAR_BALANCE) begin
                    balance_d = BALANCE_INICIAL;
                    stb_d     = 1'b1;
`ifdef LIMITE_DIARIO_EN
                    acc_d     = '0;
`endif
                end else if (REQ0 || REQ1) begin
                    // Lone requester wins outright; on a tie the pointer decides.
                    sel      = (REQ0 && REQ1) ? ptr_q : REQ1;
                    quien_d  = sel;
                    tipo_d   = sel ? TIPO1 : TIPO0;
                    monto_d  = sel ? MONTO1 : MONTO0;
                    gnt0_d   = ~sel;
                    gnt1_d   = sel;
                    estado_d = EXEC;
                end
            end
            EXEC: begin
                if (!tipo_q) begin
                    balance_d = suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
                end else begin
`ifdef LIMITE_DIARIO_EN
                    // The daily cap is judged before the funds check.
                    if (!limite_ok) begin
                        limite_d = 1'b1;
                    end else if (fondos_ok) begin
                        balance_d  = balance_q - monto_ext;
                        entregar_d = 1'b1;
                        acc_d      = acc_suma[63:0];
                    end else begin
                        fondos_d = 1'b1;
                    end
`else
                    if (fondos_ok) begin
                        balance_d  = balance_q - monto_ext;
                        entregar_d = 1'b1;
                    end else begin
                        fondos_d = 1'b1;
                    end
`endif
                end
                listo0_d = ~quien_q;
                listo1_d = quien_q;
                stb_d    = 1'b1;
                estado_d = RESP;
            end
            RESP: begin
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
                ptr_d    = ~quien_q;
                estado_d = IDLE;
            end
            default: begin
                gnt0_d   = 1'b0;
                gnt1_d   = 1'b0;
                estado_d = IDLE;
            end
        endcase
        ocupado_d = (estado_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            estado_q   <= IDLE;
            ptr_q      <= 1'b0;
            quien_q    <= 1'b0;
            tipo_q     <= 1'b0;
            monto_q    <= '0;
            balance_q  <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            listo0_q   <= 1'b0;
            listo1_q   <= 1'b0;
            entregar_q <= 1'b0;
            fondos_q   <= 1'b0;
            stb_q      <= 1'b0;
            ocupado_q  <= 1'b0;
`ifdef LIMITE_DIARIO_EN
            acc_q      <= '0;
            limite_q   <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            ptr_q      <= ptr_d;
            quien_q    <= quien_d;
            tipo_q     <= tipo_d;
            monto_q    <= monto_d;
            balance_q  <= balance_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            listo0_q   <= listo0_d;
            listo1_q   <= listo1_d;
            entregar_q <= entregar_d;
            fondos_q   <= fondos_d;
            stb_q      <= stb_d;
            ocupado_q  <= ocupado_d;
`ifdef LIMITE_DIARIO_EN
            acc_q      <= acc_d;
            limite_q   <= limite_d;
`endif
        end
    end

    assign GNT0                 = gnt0_q;
    assign GNT1                 = gnt1_q;
    assign LISTO0               = listo0_q;
    assign LISTO1               = listo1_q;
    assign ENTREGAR_DINERO      = entregar_q;
    assign FONDOS_INSUFICIENTES = fondos_q;
    assign BALANCE_ACTUALIZADO  = balance_q;
    assign BALANCE_STB          = stb_q;
    assign OCUPADO              = ocupado_q;
`ifdef LIMITE_DIARIO_EN
    assign LIMITE_EXCEDIDO      = limite_q;
`endif

endmodule

// File: doc/arbitro_balance.md
Name: arbitro_balance

Overview:
Arbiter and sequencer that shares one account-balance register and its add/subtract datapath between two ATM terminals (Cajero instances). Each terminal posts a deposit or withdrawal request; the block grants round-robin, executes one transaction at a time, and returns the result with strobes. It sits between the terminal FSMs and the shared account storage.

Parameters:
ANCHO_MONTO, 32, width of a transaction amount
ANCHO_BALANCE, 64, width of the shared balance register
LIMITE_RETIRO, 500000, cumulative withdrawal cap; used only with LIMITE_DIARIO_EN

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-low reset
CARGAR_BALANCE  input  1  load BALANCE_INICIAL into the balance register
BALANCE_INICIAL  input  ANCHO_BALANCE  value to load
REQ0 / REQ1  input  1  transaction request from terminal 0 / 1
TIPO0 / TIPO1  input  1  0 = deposit, 1 = withdrawal
MONTO0 / MONTO1  input  ANCHO_MONTO  amount from terminal 0 / 1
GNT0 / GNT1  output  1  grant to terminal 0 / 1
LISTO0 / LISTO1  output  1  one-cycle completion pulse to terminal 0 / 1
ENTREGAR_DINERO  output  1  withdrawal approved; valid with LISTOx
FONDOS_INSUFICIENTES  output  1  withdrawal rejected; valid with LISTOx
BALANCE_ACTUALIZADO  output  ANCHO_BALANCE  current balance, registered
BALANCE_STB  output  1  one-cycle pulse when BALANCE_ACTUALIZADO changes or the result is posted
OCUPADO  output  1  high in every state except IDLE

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, balance=0, round-robin pointer=0 (terminal 0 preferred), all outputs 0. Reset mid-transaction aborts it with no LISTO pulse.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - If CARGAR_BALANCE=1: load the balance, pulse BALANCE_STB on the next cycle, stay in IDLE.
  - CARGAR_BALANCE has priority over REQx in the same cycle; the requests wait.
  - CARGAR_BALANCE outside IDLE is ignored.
- IDLE with any REQx=1:
  - Select a requester. When only one is asserted, take it. When both are asserted, take the one the pointer names.
  - Latch TIPO and MONTO, assert the matching GNTx at the next edge, go to EXEC.
- EXEC (1 cycle), MONTO zero-extended to ANCHO_BALANCE:
  - Deposit: balance = balance + MONTO, saturating at 2^ANCHO_BALANCE-1.
  - Withdrawal with MONTO <= balance: balance = balance - MONTO, approved.
  - Withdrawal with MONTO > balance: balance unchanged, rejected. MONTO = 0 is always approved.
- RESP (1 cycle):
  - LISTOx=1 and BALANCE_STB=1.
  - ENTREGAR_DINERO=1 only for an approved withdrawal; FONDOS_INSUFICIENTES=1 only for a rejected withdrawal. Both are 0 for a deposit.
  - Pointer moves to the other terminal. GNTx drops at the edge leaving RESP.
- Latency: REQ sampled in cycle N -> GNT in N+1 -> LISTO/BALANCE_STB in N+2 -> OCUPADO low in N+3.
- Requester rules: hold REQx, TIPOx and MONTOx stable until LISTOx, then deassert REQx by the edge that ends LISTOx. REQx still high in IDLE counts as a new request.
- A REQx dropped during EXEC or RESP has no effect; the transaction completes.
- Only one GNTx is ever high. LISTO0 and LISTO1 are never high together.

Optional Feature:
Macro LIMITE_DIARIO_EN.
- Defined:
  - Add a 64-bit withdrawal accumulator, reset to 0 and cleared by CARGAR_BALANCE.
  - A withdrawal is rejected when accumulator + MONTO > LIMITE_RETIRO. This check is made before the funds check.
  - On rejection: new output LIMITE_EXCEDIDO (1 bit) pulses with LISTOx, and FONDOS_INSUFICIENTES=0.
  - Approved withdrawals add MONTO to the accumulator.
- Not defined: no accumulator, no LIMITE_EXCEDIDO port, no cap check.

Test Plan:
- Reset, then CARGAR_BALANCE with BALANCE_INICIAL=1000 -> BALANCE_ACTUALIZADO=1000, BALANCE_STB pulses once, OCUPADO=0.
- Balance 1000; REQ0 deposit MONTO0=250 -> GNT0 the cycle after REQ, LISTO0 the next cycle, balance 1250, ENTREGAR_DINERO=0, FONDOS_INSUFICIENTES=0.
- Balance 1250; REQ1 withdrawal 1300 -> LISTO1, FONDOS_INSUFICIENTES=1, balance stays 1250. Then withdrawal 1250 -> ENTREGAR_DINERO=1, balance 0.
- Balance 1000; REQ0 and REQ1 both withdrawal 100, asserted in the same cycle after reset -> terminal 0 served first, then terminal 1; final balance 800; GNT0 and GNT1 never high together.
- Balance 2^64-10; deposit 100 -> balance 2^64-1 (saturated). Assert RESET during EXEC of a later request -> no LISTO, balance 0, GNT0=GNT1=0.
- With LIMITE_DIARIO_EN and LIMITE_RETIRO=500: balance 10000; withdrawal 400 approved; next withdrawal 200 -> LIMITE_EXCEDIDO=1, balance 9600.
